// File: rtl/mips_mem_pkg.sv
// Shared types and sizing for the MEM-stage data cache.
package mips_mem_pkg;

  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_ADDR_W     = 32;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_MEM, RESP} state_e;

  function automatic int tag_w(input int addr_w, input int index_bits);
    return addr_w - 2 - index_bits;
  endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Main-memory request/acknowledge bus between the data cache and memory.
interface data_cache_ctrl_if #(parameter int ADDR_W = 32);

  logic              mm_req;
  logic              mm_we;
  logic [ADDR_W-1:0] mm_addr;
  logic [31:0]       mm_wdata;
  logic              mm_ack;
  logic [31:0]       mm_rdata;

  modport master (output mm_req, mm_we, mm_addr, mm_wdata, input mm_ack, mm_rdata);
  modport slave  (input mm_req, mm_we, mm_addr, mm_wdata, output mm_ack, mm_rdata);

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, synchronous write.
module dcache_array import mips_mem_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_W      = tag_w(DEF_ADDR_W, DEF_INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data are don't-care until their valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Write-through, read-allocate direct-mapped data cache for the MIPS MEM stage.
module data_cache_ctrl import mips_mem_pkg::*; #(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              hit,
  data_cache_ctrl_if.master mm,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       fill_q, fill_d;
  logic [15:0]       miss_q, miss_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [ADDR_W-1:0]     word_addr;
  logic                  rd_valid, tag_hit, arr_we;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data, arr_wdata;
  logic                  unused_byte_off;

  assign idx             = addr[INDEX_BITS+1:2];
  assign tag             = addr[ADDR_W-1:INDEX_BITS+2];
  assign word_addr       = {addr[ADDR_W-1:2], 2'b00};
  assign unused_byte_off = ^addr[1:0];
  assign tag_hit         = rd_valid && (rd_tag == tag);

  // Request inputs are held stable while stalled, so the live index/tag
  // also address the line being filled or updated on ack.
  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (arr_wdata)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    fill_d    = fill_q;
    miss_d    = miss_q;
    hit       = 1'b1;
    read_data = '0;
    arr_we    = 1'b0;
    arr_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          hit     = 1'b0;
          state_d = WRITE_MEM;
          req_d   = 1'b1;
          we_d    = 1'b1;
          maddr_d = word_addr;
          wdata_d = write_data;
        end else if (mem_read) begin
          if (tag_hit) begin
            read_data = rd_data;
          end else begin
            hit     = 1'b0;
            state_d = READ_MISS;
            req_d   = 1'b1;
            we_d    = 1'b0;
            maddr_d = word_addr;
            miss_d  = miss_q + 16'd1;
          end
        end
      end
      READ_MISS: begin
        hit = 1'b0;
        if (mm.mm_ack) begin
          arr_we    = 1'b1;
          arr_wdata = mm.mm_rdata;
          fill_d    = mm.mm_rdata;
          req_d     = 1'b0;
          state_d   = RESP;
        end
      end
      WRITE_MEM: begin
        hit = 1'b0;
        if (mm.mm_ack) begin
          arr_we  = tag_hit;  // no allocate on write miss
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (mem_read && !mem_write) read_data = fill_q;
      end
      default: state_d = IDLE;
    endcase
    // Present reset-state outputs while reset is held, whatever the request.
    if (!rst_n) begin
      hit       = 1'b1;
      read_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      fill_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      fill_q  <= fill_d;
      miss_q  <= miss_d;
    end
  end

  assign mm.mm_req   = req_q;
  assign mm.mm_we    = we_q;
  assign mm.mm_addr  = maddr_q;
  assign mm.mm_wdata = wdata_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: directed accesses, queued expectations.
module tb_data_cache_ctrl;

  localparam int IB = 4;
  localparam int AW = 32;

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] mc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wd;
  } mm_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [31:0] read_data;
  logic        hit;
  logic [15:0] miss_count;
  logic        ack_m = 1'b0, ack_s = 1'b0;
  logic [31:0] rdata_m = '0, mem_rdata = '0;
  int          ack_delay = 0;

  int checks = 0;
  int failures = 0;

  rsp_t rsp_q[$];
  mm_t  mm_q[$];

  always #5 clk = ~clk;

  data_cache_ctrl_if #(.ADDR_W(AW)) mm();
  assign mm.mm_ack   = ack_m | ack_s;
  assign mm.mm_rdata = rdata_m;

  data_cache_ctrl #(.INDEX_BITS(IB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .mm         (mm.master),
    .miss_count (miss_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: ack ack_delay cycles after mm_req is first seen.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mm.mm_req && !ack_m) begin
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge clk);
          if (!mm.mm_req) break;
        end
        if (mm.mm_req) begin
          ack_m   = 1'b1;
          rdata_m = mem_rdata;
          @(negedge clk);
          ack_m = 1'b0;
        end
      end
    end
  end

  // Monitor: memory-side transactions and pipeline-side completions.
  bit  req_prev = 1'b0;
  bit  have_cur = 1'b0;
  mm_t cur;
  int  lat = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lat      = 0;
      req_prev = 1'b0;
    end else begin
      if (mm.mm_req) begin
        if (!req_prev) begin
          if (mm_q.size() == 0) begin
            checks++;
            failures++;
            have_cur = 1'b0;
            $display("FAIL mm_unexpected: mm_req rose addr 0x%08h with no transaction expected", mm.mm_addr);
          end else begin
            cur      = mm_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          chk("mm_we", {31'd0, mm.mm_we}, {31'd0, cur.we});
          chk("mm_addr", mm.mm_addr, cur.addr);
          if (cur.chk_wd) chk("mm_wdata", mm.mm_wdata, cur.wdata);
        end
      end
      req_prev = mm.mm_req;
      if (mem_read || mem_write) begin
        if (hit) begin
          if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: hit with no response expected");
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("read_data", read_data, r.rdata);
            chk("miss_count", {16'd0, miss_count}, {16'd0, r.mc});
            chk("stall_cycles", lat, r.lat);
          end
          lat = 0;
        end else begin
          lat++;
        end
      end
    end
  end

  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mrd, input int k, input bit exp_mm,
                           input logic [31:0] e_rd, input logic [15:0] e_mc, input int e_lat);
    rsp_t r;
    mm_t  m;
    bit   done;
    r.rdata = e_rd;
    r.mc    = e_mc;
    r.lat   = e_lat;
    rsp_q.push_back(r);
    if (exp_mm) begin
      m.we     = wr;
      m.addr   = {a[31:2], 2'b00};
      m.wdata  = wd;
      m.chk_wd = wr;
      mm_q.push_back(m);
    end
    mem_rdata  = mrd;
    ack_delay  = k;
    addr       = a;
    write_data = wd;
    mem_write  = wr;
    mem_read   = !wr;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = hit;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: addr 0x%08h never completed", a);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    // Reset state, held and then released with no request.
    @(negedge clk);
    chk("rst_hit", {31'd0, hit}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_mm_req", {31'd0, mm.mm_req}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hit", {31'd0, hit}, 32'd1);
    chk("idle_read_data", read_data, 32'd0);
    chk("idle_mm_req", {31'd0, mm.mm_req}, 32'd0);
    @(posedge clk); #1;

    // Read miss (ack 3 cycles after req), then a same-cycle read hit.
    do_access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3, 1'b1, 32'hDEADBEEF, 16'd1, 5);
    do_access(1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF, 16'd1, 0);
    // Conflict misses on index 0.
    do_access(1'b0, 32'h440, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 16'd2, 2);
    do_access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF, 16'd3, 3);
    // Write hit updates the resident word.
    do_access(1'b1, 32'h40, 32'h12345678, 32'h0, 2, 1'b1, 32'h0, 16'd3, 4);
    do_access(1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0, 32'h12345678, 16'd3, 0);
    // Spurious ack in IDLE is ignored.
    ack_s = 1'b1;
    @(posedge clk); #1 ack_s = 1'b0;
    do_access(1'b0, 32'h43, 32'h0, 32'h0, 0, 1'b0, 32'h12345678, 16'd3, 0);
    // Write miss to the same index: memory only, resident 0x40 untouched.
    do_access(1'b1, 32'h80, 32'h5A5A0001, 32'h0, 0, 1'b1, 32'h0, 16'd3, 2);
    do_access(1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0, 32'h12345678, 16'd3, 0);
    do_access(1'b0, 32'h80, 32'h0, 32'h5A5A0001, 1, 1'b1, 32'h5A5A0001, 16'd4, 3);
    do_access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 16'd5, 2);

    // Reset during READ_MISS with the load still asserted.
    begin
      mm_t m;
      m.we = 1'b0; m.addr = 32'h4C; m.wdata = '0; m.chk_wd = 1'b0;
      mm_q.push_back(m);
    end
    ack_delay = 50;
    addr      = 32'h4C;
    mem_read  = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mm_req", {31'd0, mm.mm_req}, 32'd0);
    chk("midrst_hit", {31'd0, hit}, 32'd1);
    chk("midrst_read_data", read_data, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_miss_count", {16'd0, miss_count}, 32'd0);
    @(posedge clk); #1;
    do_access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 16'd1, 2);

    repeat (3) @(negedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("mm_queue_drained", mm_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
